rom_fetch_ctrl: RTL

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

---
 rtl/rom_fetch_pkg.sv | 26 ++
 rtl/rom_fetch_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared constants and FSM encoding for the ROM fetch controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rom_fetch_pkg;

    // Default geometry of the ROM port and request tag.
    localparam int ROM_DATA_WIDTH = 128;
    localparam int ROM_ADDR_WIDTH = 25;
    localparam int ROM_ID_WIDTH   = 4;

    // Latency counter width: covers accept-to-response latencies of 1..15.
    localparam int CNT_WIDTH      = 4;

    // Fetch FSM: IDLE (free), WAIT (ROM access in flight), RESP (response held).
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_RESP = 2'd2
    } fetch_state_e;

    // Plain-vector aliases of the enum for legacy code that keeps state as logic.
    localparam logic [1:0] ST_IDLE = FETCH_IDLE;
    localparam logic [1:0] ST_WAIT = FETCH_WAIT;
    localparam logic [1:0] ST_RESP = FETCH_RESP;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Single-outstanding fetch front-end for a combinational ROM, returning one aligned line per request.
// Latency: response valid exactly LATENCY cycles after the accepting edge (LATENCY legal range 1..15).
// Backpressure: response held stable until resp_ready; new request accepted only when idle or on the response handshake edge.
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int ID_WIDTH   = ROM_ID_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] rom_raddr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    // Number of address bits that select a position inside one ROM line.
    localparam int OFFS = $clog2(DATA_WIDTH);

    // Address bits kept when pointing at the start of a line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));

    // Counter load value: a WAIT phase lasting LATENCY cycles ends when the counter reads 0.
    localparam logic [CNT_WIDTH-1:0] LAT_M1 = CNT_WIDTH'(LATENCY - 1);

    // Captured request, held for the whole WAIT/RESP lifetime of the transaction.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic                  in_idle;
    logic                  in_wait;
    logic                  in_resp;
    logic                  accept;
    logic                  line_done;
    logic                  misaligned;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_wait    = (state_q == ST_WAIT);
    assign in_resp    = (state_q == ST_RESP);

    // A request may enter when the block is free, or on the very edge the held response leaves.
    assign req_ready  = in_idle | (in_resp & resp_ready);
    assign accept     = req_valid & req_ready;

    // The ROM read completes on the last WAIT cycle.
    assign line_done  = in_wait & (cnt_q == '0);

    // Any set offset bit means the caller did not point at a line boundary.
    assign misaligned = |(req_q.addr & ~LINE_MASK);

    // The ROM always sees the line-aligned version of the captured address.
    assign rom_raddr  = req_q.addr & LINE_MASK;

    // Response outputs come straight from registers, so resp_valid never sees resp_ready combinationally.
    assign resp_valid = in_resp;
    assign resp_data  = data_q;
    assign resp_id    = req_q.id;
    assign resp_err   = err_q;

    // Next-state selection for the fetch FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (line_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Handshake plus new request chains straight into the next access.
                if (accept) begin
                    state_d = ST_WAIT;
                end else if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction so it never responds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latency counter: loaded on accept, counts down to zero while waiting on the ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= LAT_M1;
        end else if (in_wait && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    // Request capture; address and id stay frozen until the next accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.addr <= req_addr;
            req_q.id   <= req_id;
        end
    end

    // Response capture: line data and alignment flag update together as WAIT ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (line_done) begin
            data_q <= rom_rdata;
            err_q  <= misaligned;
        end
    end

endmodule
